// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the data-port request state machine encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_t;

endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation: one {valid, addr} link plus the store-conditional match check.
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic              store_done_i,
  input  logic [WORD_W-1:0] store_addr_i,
  input  logic              snoop_inv_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  input  logic [WORD_W-1:0] chk_addr_i,
  output logic              match_o
);

  logic  valid_q;
  word_t addr_q;

  // A new reservation outranks any invalidation arriving in the same cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (set_i) begin
      valid_q <= 1'b1;
      addr_q  <= set_addr_i;
    end else if ((snoop_inv_i && (snoop_addr_i == addr_q)) ||
                 (store_done_i && (store_addr_i == addr_q))) begin
      valid_q <= 1'b0;
    end
  end

  assign match_o = valid_q && (addr_q == chk_addr_i);

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data-port initiator: issues one dcache access, stalls until dhit, holds the result.
// Define DMEM_LLSC_EN to add load-linked / store-conditional support via llsc_link.
module dmem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WAIT_W = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic [WORD_W-1:0] dmemload_in,
  output logic [WORD_W-1:0] dmemload_out,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [WAIT_W-1:0] wait_cnt
);

  dmem_state_t       state_q;
  word_t             addr_q, store_q, load_q;
  logic              rd_q, ren_q, wen_q, done_q, flushed_q;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  logic  start;
  logic  discard;
  logic  sc_fail;
  logic  hit_writes_result;
  word_t hit_result;

  assign start   = (state_q == IDLE) && (memRead_in || memWrite_in) && !flush;
  assign discard = flush || flushed_q;
  assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};

`ifdef DMEM_LLSC_EN
  logic ll_q, sc_q, link_match;

  // A failing sc is resolved at issue time and never reaches the bus.
  assign sc_fail           = start && memWrite_in && !memRead_in && sc_in && !link_match;
  assign hit_writes_result = rd_q || sc_q;
  assign hit_result        = sc_q ? word_t'(1) : dmemload_in;

  llsc_link u_link (
    .CLK          (CLK),
    .nRST         (nRST),
    .set_i        ((state_q == REQ) && dhit && !discard && ll_q),
    .set_addr_i   (addr_q),
    .store_done_i ((state_q == REQ) && dhit && wen_q),
    .store_addr_i (addr_q),
    .snoop_inv_i  (snoop_inv),
    .snoop_addr_i (snoop_addr),
    .chk_addr_i   (addr_in),
    .match_o      (link_match)
  );
`else
  logic unused_llsc;

  assign sc_fail           = 1'b0;
  assign hit_writes_result = rd_q;
  assign hit_result        = dmemload_in;
  assign unused_llsc       = ^{ll_in, sc_in, snoop_inv, snoop_addr};
`endif

  // NOTE: every register here uses <= so all updates see the pre-edge values, with no ordering hazards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      load_q    <= '0;
      rd_q      <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
      flushed_q <= 1'b0;
      cnt_q     <= '0;
`ifdef DMEM_LLSC_EN
      ll_q      <= 1'b0;
      sc_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q    <= addr_in;
            store_q   <= store_in;
            rd_q      <= memRead_in;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
`ifdef DMEM_LLSC_EN
            ll_q      <= memRead_in && ll_in;
            sc_q      <= memWrite_in && !memRead_in && sc_in;
`endif
            if (sc_fail) begin
              load_q  <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Read wins if both strobes arrive, so REN and WEN stay exclusive.
              ren_q   <= memRead_in;
              wen_q   <= memWrite_in && !memRead_in;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_d;
          if (flush) flushed_q <= 1'b1;
          if (dhit) begin
            ren_q <= 1'b0;
            wen_q <= 1'b0;
            if (discard) begin
              state_q <= IDLE;
            end else begin
              if (hit_writes_result) load_q <= hit_result;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (ihit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmemREN      = ren_q;
  assign dmemWEN      = wen_q;
  assign dmemaddr     = addr_q;
  assign dmemstore    = store_q;
  assign dmemload_out = load_q;
  assign mem_done     = done_q;
  assign wait_cnt     = cnt_q;
  assign mem_stall    = start || (state_q == REQ);

endmodule
